hh_gate_sequencer: RTL

- Per-timestep controller for the Hodgkin-Huxley neuron core.
- Time-multiplexes one shared gate-update unit (Euler step of dx/dt = alpha·(1−x) − beta·x) across the m, h and n gates, then triggers the membrane integrator.
- Owns the m/h/n state registers, clamps unit results to the valid gate range, and reports step completion and overruns.

---
 rtl/hh_gate_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/hh_gate_sequencer.sv
// -----------------------------------------------------------------------------
// hh_gate_sequencer
//
// Per-timestep controller for the Hodgkin-Huxley neuron core. One shared
// gate-update unit (Euler step of dx/dt = alpha*(1-x) - beta*x) is
// time-multiplexed across the m, h and n gates in that fixed order, after
// which the membrane integrator is started. The block owns the committed
// m/h/n registers, clamps each unit result into the unsigned Q0.W range and
// reports step completion and dropped step requests.
//
// Optional build macro:
//   HH_TIMEOUT_EN - adds a per-state wait counter. If gu_done/mem_done does
//                   not arrive within TIMEOUT cycles, err is set (sticky) and
//                   the FSM returns to IDLE without step_done. When undefined
//                   the FSM waits indefinitely and err is tied to 0.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   step_tick    in   one-cycle request for one integration timestep
//   gu_start     out  one-cycle start pulse to the shared gate unit
//   gu_sel       out  gate being updated: 0=m, 1=h, 2=n
//   gu_x         out  current value of the selected gate
//   gu_done      in   gate unit result valid (one-cycle pulse)
//   gu_x_next    in   signed W+2-bit unit result, same scale as gu_x
//   mem_start    out  one-cycle start pulse to the membrane integrator
//   mem_done     in   integrator finished (one-cycle pulse)
//   m_out/h_out/n_out out committed gate registers
//   busy         out  high in every state except IDLE
//   step_done    out  one-cycle pulse when a timestep completes
//   overrun_cnt  out  step_tick pulses dropped while busy, saturating at 255
//   err          out  sticky timeout flag (HH_TIMEOUT_EN only, else 0)
// -----------------------------------------------------------------------------
module hh_gate_sequencer #(
    parameter int unsigned W       = 16,
    parameter int unsigned M_REST  = 3277,
    parameter int unsigned H_REST  = 39322,
    parameter int unsigned N_REST  = 20972,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_tick,
    output logic         gu_start,
    output logic [1:0]   gu_sel,
    output logic [W-1:0] gu_x,
    input  logic         gu_done,
    input  logic [W+1:0] gu_x_next,
    output logic         mem_start,
    input  logic         mem_done,
    output logic [W-1:0] m_out,
    output logic [W-1:0] h_out,
    output logic [W-1:0] n_out,
    output logic         busy,
    output logic         step_done,
    output logic [7:0]   overrun_cnt,
    output logic         err
);

    // State encoding kept as plain constants for legacy tool compatibility.
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StGateM = 3'd1;
    localparam logic [2:0] StGateH = 3'd2;
    localparam logic [2:0] StGateN = 3'd3;
    localparam logic [2:0] StMem   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    localparam logic [W-1:0] MRest = W'(M_REST);
    localparam logic [W-1:0] HRest = W'(H_REST);
    localparam logic [W-1:0] NRest = W'(N_REST);

    logic [2:0]   state_q, state_d;
    // High only in the first cycle of a GATE_x or MEM state; drives the start
    // pulses and masks a done that coincides with its own start.
    logic         first_q, first_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] n_q, n_d;
    logic [7:0]   ovr_q, ovr_d;

    logic [W-1:0] clamped;
    logic         gu_ok;
    logic         mem_ok;
    logic         timeout_hit;

    // -------------------------------------------------------------------------
    // Clamp the signed unit result into [0, 2^W-1]. Bit W+1 is the sign; any
    // non-negative value with bit W set lies above the representable range.
    // -------------------------------------------------------------------------
    always_comb begin
        if (gu_x_next[W+1]) begin
            clamped = '0;
        end else if (gu_x_next[W]) begin
            clamped = '1;
        end else begin
            clamped = gu_x_next[W-1:0];
        end
    end

    assign gu_ok  = gu_done && !first_q;
    assign mem_ok = mem_done && !first_q;

`ifdef HH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            waiting;

    assign waiting = (state_q == StGateM) || (state_q == StGateH) ||
                     (state_q == StGateN) || (state_q == StMem);

    // Fires in the TIMEOUT-th cycle spent waiting in the current state.
    assign timeout_hit = waiting && (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (!first_d && waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A waiting state only falls back to IDLE through a timeout.
    assign err_d = err_q || (timeout_hit && (state_d == StIdle));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. A timeout leaves the in-flight gate untouched.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        m_d     = m_q;
        h_d     = h_q;
        n_d     = n_q;

        case (state_q)
            StIdle: begin
                if (step_tick) begin
                    state_d = StGateM;
                    first_d = 1'b1;
                end
            end
            StGateM: begin
                if (gu_ok) begin
                    m_d     = clamped;
                    state_d = StGateH;
                    first_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StGateH: begin
                if (gu_ok) begin
                    h_d     = clamped;
                    state_d = StGateN;
                    first_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StGateN: begin
                if (gu_ok) begin
                    n_d     = clamped;
                    state_d = StMem;
                    first_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StMem: begin
                if (mem_ok) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Requests arriving outside IDLE are dropped and counted, never queued.
    always_comb begin
        ovr_d = ovr_q;
        if (step_tick && (state_q != StIdle) && (ovr_q != 8'hff)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            first_q <= 1'b0;
            m_q     <= MRest;
            h_q     <= HRest;
            n_q     <= NRest;
            ovr_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            m_q     <= m_d;
            h_q     <= h_d;
            n_q     <= n_d;
            ovr_q   <= ovr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. gu_sel/gu_x are pure functions of the state, so they hold for
    // the whole GATE_x state; the selected gate is only written on exit.
    // -------------------------------------------------------------------------
    always_comb begin
        gu_sel = 2'd0;
        case (state_q)
            StGateH: gu_sel = 2'd1;
            StGateN: gu_sel = 2'd2;
            default: gu_sel = 2'd0;
        endcase
    end

    always_comb begin
        gu_x = m_q;
        case (gu_sel)
            2'd1:    gu_x = h_q;
            2'd2:    gu_x = n_q;
            default: gu_x = m_q;
        endcase
    end

    assign gu_start  = first_q && ((state_q == StGateM) || (state_q == StGateH) ||
                                   (state_q == StGateN));
    assign mem_start = first_q && (state_q == StMem);
    assign step_done = (state_q == StDone);
    assign busy      = (state_q != StIdle);

    assign m_out       = m_q;
    assign h_out       = h_q;
    assign n_out       = n_q;
    assign overrun_cnt = ovr_q;

endmodule
